sprite_addr_gen: RTL and testbench

SPRITE_ADDR_GEN -- requirements
Module: sprite_addr_gen

---
 rtl/sprite_pkg.sv | 8 +
 rtl/sprite_frame_timer.sv | 46 ++++
 rtl/sprite_addr_gen.sv | 115 +++++++++++
 tb/tb_sprite_addr_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite address generator: screen geometry,
// coordinate width and sprite ROM address width.
package sprite_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int ROM_AW   = 12;
endpackage

// File: rtl/sprite_frame_timer.sv
// Vsync falling-edge detector and animation stepper: every FRAME_DIV video
// frames (while anim_en is high) anim_idx advances modulo NUM_FRAMES.
module sprite_frame_timer
    import sprite_pkg::*;
#(
    parameter int FRAME_DIV  = 8,
    parameter int NUM_FRAMES = 4,
    parameter int IDX_W      = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             vsync,
    input  logic             anim_en,
    output logic             frame_start,
    output logic [IDX_W-1:0] anim_idx
);
    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);

    logic             vsync_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [IDX_W-1:0] anim_idx_q;

    // vsync idles high, so the registered copy resets high to avoid a false edge
    assign frame_start = vsync_q & ~vsync;
    assign anim_idx    = anim_idx_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q     <= 1'b1;
            frame_cnt_q <= '0;
            anim_idx_q  <= '0;
        end else begin
            vsync_q <= vsync;
            if (frame_start && anim_en) begin
                if (frame_cnt_q == CNT_LAST) begin
                    frame_cnt_q <= '0;
                    anim_idx_q  <= (anim_idx_q == IDX_LAST) ? '0 : anim_idx_q + 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sprite_addr_gen.sv
// Two-stage sprite ROM address generator with per-frame position shadowing.
// Optional horizontal mirroring is enabled by defining SPRITE_HFLIP_EN.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_DIV  = 8
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] drawX,
    input  logic [COORD_W-1:0] drawY,
    input  logic               blank,
    input  logic               vsync,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               anim_en,
    input  logic               facing_left,
    output logic [ROM_AW-1:0]  rom_address,
    output logic               sprite_on,
    output logic               blank_out
);
    localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [COORD_W:0] W_LIM = (COORD_W + 1)'(SPRITE_W);
    localparam logic [COORD_W:0] H_LIM = (COORD_W + 1)'(SPRITE_H);

    logic               frame_start;
    logic [IDX_W-1:0]   anim_idx;
    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic [COORD_W:0]   rel_x_d, rel_y_d, rel_x_q, rel_y_q;
    logic               in_x_d, in_y_d, in_x_q, in_y_q, blank_d1_q;
    logic [COORD_W:0]   col;
    logic               sprite_on_d;
    logic [ROM_AW-1:0]  rom_addr_d;

    sprite_frame_timer #(
        .FRAME_DIV  (FRAME_DIV),
        .NUM_FRAMES (NUM_FRAMES),
        .IDX_W      (IDX_W)
    ) u_timer (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .vsync       (vsync),
        .anim_en     (anim_en),
        .frame_start (frame_start),
        .anim_idx    (anim_idx)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else if (frame_start) begin
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
        end
    end

`ifdef SPRITE_HFLIP_EN
    logic facing_q;
    localparam logic [COORD_W:0] COL_MAX = (COORD_W + 1)'(SPRITE_W - 1);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)         facing_q <= 1'b0;
        else if (frame_start) facing_q <= facing_left;
    end

    assign col = facing_q ? (COL_MAX - rel_x_q) : rel_x_q;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
    assign col = rel_x_q;
`endif

    // The sign bit of the 11-bit difference rejects pixels left/above the sprite
    always_comb begin
        rel_x_d = {1'b0, drawX} - {1'b0, pos_x_q};
        rel_y_d = {1'b0, drawY} - {1'b0, pos_y_q};
        in_x_d  = !rel_x_d[COORD_W] && (rel_x_d < W_LIM);
        in_y_d  = !rel_y_d[COORD_W] && (rel_y_d < H_LIM);
    end

    always_comb begin
        sprite_on_d = in_x_q & in_y_q & blank_d1_q;
        rom_addr_d  = '0;
        if (sprite_on_d) begin
            rom_addr_d = ROM_AW'(32'(anim_idx) * 32'(SPRITE_W * SPRITE_H)
                                 + 32'(rel_y_q) * 32'(SPRITE_W) + 32'(col));
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rel_x_q     <= '0;
            rel_y_q     <= '0;
            in_x_q      <= 1'b0;
            in_y_q      <= 1'b0;
            blank_d1_q  <= 1'b0;
            rom_address <= '0;
            sprite_on   <= 1'b0;
            blank_out   <= 1'b0;
        end else begin
            rel_x_q     <= rel_x_d;
            rel_y_q     <= rel_y_d;
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            blank_d1_q  <= blank;
            rom_address <= rom_addr_d;
            sprite_on   <= sprite_on_d;
            blank_out   <= blank_d1_q;
        end
    end
endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen with hand-computed expected values;
// the mirrored-address expectation follows SPRITE_HFLIP_EN.
module tb_sprite_addr_gen;
    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  drawX = '0, drawY = '0, pos_x = '0, pos_y = '0;
    logic        blank = 1'b0, vsync = 1'b1, anim_en = 1'b0, facing_left = 1'b0;
    logic [11:0] rom_address;
    logic        sprite_on, blank_out;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_addr_gen dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .drawX       (drawX),
        .drawY       (drawY),
        .blank       (blank),
        .vsync       (vsync),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .anim_en     (anim_en),
        .facing_left (facing_left),
        .rom_address (rom_address),
        .sprite_on   (sprite_on),
        .blank_out   (blank_out)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // one vsync falling edge, inputs changed 1 ns after the clock edge
    task automatic vfall();
        vsync = 1'b0;
        @(posedge vga_clk); #1;
        vsync = 1'b1;
        @(posedge vga_clk); #1;
    endtask

    task automatic vfalls(input int n);
        for (int i = 0; i < n; i++) vfall();
    endtask

    // drive a pixel and check the outputs two clocks later
    task automatic pix(input string tag, input int x, input int y, input logic b,
                       input logic exp_on, input int exp_addr, input logic exp_bo);
        drawX = 10'(x);
        drawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        @(posedge vga_clk); #1;
        chk({tag, "_on"},    {31'd0, sprite_on}, {31'd0, exp_on});
        chk({tag, "_addr"},  {20'd0, rom_address}, 32'(exp_addr));
        chk({tag, "_blank"}, {31'd0, blank_out}, {31'd0, exp_bo});
    endtask

    initial begin
        int flip_addr;
        #23;
        chk("rst_addr",  {20'd0, rom_address}, 32'd0);
        chk("rst_on",    {31'd0, sprite_on}, 32'd0);
        chk("rst_blank", {31'd0, blank_out}, 32'd0);

        @(posedge vga_clk); #1;
        reset_n = 1'b1;
        pos_x = 10'd100;
        pos_y = 10'd50;
        @(posedge vga_clk); #1;
        vfall();

        pix("origin",    100, 50, 1'b1, 1'b1, 0,    1'b1);
        pix("last_px",   131, 81, 1'b1, 1'b1, 1023, 1'b1);
        pix("right_out", 132, 81, 1'b1, 1'b0, 0,    1'b1);
        pix("left_out",  99,  50, 1'b1, 1'b0, 0,    1'b1);
        pix("above",     100, 49, 1'b1, 1'b0, 0,    1'b1);
        pix("below",     131, 82, 1'b1, 1'b0, 0,    1'b1);
        pix("blanked",   105, 52, 1'b0, 1'b0, 0,    1'b0);
        pix("mid",       110, 60, 1'b1, 1'b1, 330,  1'b1);

        anim_en = 1'b1;
        vfalls(8);
        pix("anim1", 100, 50, 1'b1, 1'b1, 1024, 1'b1);
        vfalls(8);
        pix("anim2", 100, 50, 1'b1, 1'b1, 2048, 1'b1);
        vfalls(8);
        pix("anim3", 131, 81, 1'b1, 1'b1, 4095, 1'b1);
        vfalls(8);
        pix("anim_wrap", 100, 50, 1'b1, 1'b1, 0, 1'b1);

        vfalls(3);
        anim_en = 1'b0;
        vfalls(10);
        anim_en = 1'b1;
        vfalls(4);
        pix("hold_pre", 100, 50, 1'b1, 1'b1, 0, 1'b1);
        vfall();
        pix("hold_step", 100, 50, 1'b1, 1'b1, 1024, 1'b1);
        anim_en = 1'b0;

        pos_x = 10'd200;
        pix("shadow_new_out", 200, 50, 1'b1, 1'b0, 0,    1'b1);
        pix("shadow_old_in",  100, 50, 1'b1, 1'b1, 1024, 1'b1);
        vfall();
        pix("shadow_new_in",  200, 50, 1'b1, 1'b1, 1024, 1'b1);

        facing_left = 1'b1;
        vfall();
`ifdef SPRITE_HFLIP_EN
        flip_addr = 1024 + 31;
`else
        flip_addr = 1024;
`endif
        pix("hflip",       200, 50, 1'b1, 1'b1, flip_addr, 1'b1);
        pix("hflip_blank", 200, 50, 1'b0, 1'b0, 0,         1'b0);
        facing_left = 1'b0;

        pos_x = 10'd620;
        vfall();
        pix("edge_in",  639, 50, 1'b1, 1'b1, 1043, 1'b1);
        pix("edge_nowrap", 0, 50, 1'b1, 1'b0, 0,   1'b1);

        pos_x = 10'd100;
        anim_en = 1'b1;
        vfalls(8);
        anim_en = 1'b0;
        pix("pre_reset", 100, 50, 1'b1, 1'b1, 2048, 1'b1);

        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr",  {20'd0, rom_address}, 32'd0);
        chk("mid_rst_on",    {31'd0, sprite_on}, 32'd0);
        chk("mid_rst_blank", {31'd0, blank_out}, 32'd0);
        @(posedge vga_clk); #1;
        reset_n = 1'b1;
        pix("post_rst_idx0", 5, 3, 1'b1, 1'b1, 101, 1'b1);
        pix("post_rst_oldpos", 100, 50, 1'b1, 1'b0, 0, 1'b1);
        vfall();
        pix("post_rst_newpos", 100, 50, 1'b1, 1'b1, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
